conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 MAC array.
//  Accepts one pixel per valid cycle in raster order.
//  Buffers two previous image rows in internal line buffers.
//  Emits every full 3x3 neighbourhood ("valid" convolution, no padding) as a packed 9-element
//  bus wired straight to the MAC array's window_data / valid_in inputs.
// PARAMETERS
//  DATA_WIDTH  8   bits per pixel; equals the MAC array's DATA_WIDTH
//  IMG_WIDTH   28  pixels per row; legal range >=3
//  IMG_HEIGHT  28  rows per frame; legal range >=3
// PORTS
//  clk           in   1             rising-edge clock
//  rst_n         in   1             synchronous reset, active low
//  pixel_in      in   DATA_WIDTH    input pixel
//  pixel_valid   in   1             pixel_in is accepted this cycle
//  pixel_sof     in   1             qualified by pixel_valid: this pixel is (row 0, col 0)
//  window_data   out  9*DATA_WIDTH  slot g=r*3+c at [g*DATA_WIDTH +: DATA_WIDTH]
//                                   r=0 is the oldest row, c=0 the oldest column
//  window_valid  out  1             window_data holds a new full window this cycle
//  window_last   out  1             only with CONV_WINDOW_LAST_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset: on clk edge with rst_n=0, clear all of the following to 0:
//      col/row counters, 3x3 window registers, window_valid, window_last.
//    Line-buffer RAM contents need not be cleared.
//    Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
//  - Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance only on pixel_valid.
//      col wraps to 0 and increments row; at (H-1,W-1) both wrap to 0 (next frame).
//  - pixel_valid with pixel_sof: the pixel is treated as (0,0) regardless of counter state
//    (resync / abort of a partial frame); counters then continue from (0,1).
//    pixel_sof without pixel_valid is ignored.
//  - Two line buffers LB0 (previous row) and LB1 (row before that), depth IMG_WIDTH,
//    indexed by col. On an accepted pixel:
//      shift window left one column
//      new right column (c=2) = {r0:LB1[col], r1:LB0[col], r2:pixel_in}
//      then LB1[col]<=LB0[col], LB0[col]<=pixel_in   (read-before-write, same cycle)
//  - Output gating: window_valid<=1 on the cycle after accepting pixel (row,col) with
//    row>=2 && col>=2. Otherwise window_valid<=0, including all pixel_valid=0 cycles.
//  - Latency: 1 clock from accepted pixel to its window.
//  - Yield: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
//  - The col>=2 gate guarantees no window mixes pixels across a row boundary.
//  - Stale line-buffer data from the previous frame is never visible: rows 0-1 are gated.
//  - Input gaps (pixel_valid=0) of any length are legal: state holds and window_data holds its
//    last value. window_data content is don't-care while window_valid=0.
//  - No backpressure: downstream must accept one window per cycle, which the MAC array does.
//  - Pure data movement: no arithmetic, no sign handling. Signedness is the MAC array's concern.
// CONFIGURATION
//  CONV_WINDOW_LAST_EN defined:
//    port window_last exists; registered with the same 1-cycle latency as window_valid.
//    It is 1 only together with the window_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1),
//    i.e. the final window of the frame.
//  CONV_WINDOW_LAST_EN undefined:
//    port and logic absent; all other behaviour identical.
// TESTING  (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value=row*16+col, sof on (0,0))
//  1. One gap-free frame.
//     -> Exactly 6 window_valid pulses; the first is the cycle after pixel (2,2), with
//        g0..g8=0x00,01,02,10,11,12,20,21,22.
//     -> The last pulse has g0..g8=0x12,13,14,22,23,24,32,33,34.
//  2. Same frame with random 0-3 cycle gaps in pixel_valid.
//     -> Identical 6 windows in identical order; window_valid never high during a gap
//        except the latency cycle.
//  3. Two back-to-back frames, second with values +0x80.
//     -> 12 windows; the first window of frame 2 contains no frame-1 value
//        (g0=0x80, g8=0xA2).
//  4. pixel_sof asserted at frame-1 pixel (3,1), then a full frame.
//     -> No window built from pre-sof pixels; the next 6 windows match scenario 1.
//  5. rst_n=0 for 1 cycle right after pixel (2,3).
//     -> The next cycle has window_valid=0 (and window_last=0).
//     -> A fresh frame then yields the scenario-1 windows.
//  6. With CONV_WINDOW_LAST_EN, scenario 1.
//     -> window_last=1 only on the 6th window_valid.
//     -> Feeding the frame-1 pixels into the MAC array with all weights=1 yields a first
//        mac_out of 0x99 (=153).

Source files
------------

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: raster pixels in, packed 3x3 neighbourhoods out.
// Optional feature macro: CONV_WINDOW_LAST_EN (adds window_last, end-of-frame window flag).
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic                    pixel_valid,
    input  logic                    pixel_sof,
    output logic [9*DATA_WIDTH-1:0] window_data,
    output logic                    window_valid
`ifdef CONV_WINDOW_LAST_EN
    ,
    output logic                    window_last
`endif
);

    // Handshake: valid-only, no ready. pixel_valid accepts pixel_in that cycle; window_valid
    // marks a fresh window_data for exactly one cycle and downstream must take it.

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    logic [DATA_WIDTH-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;

    logic [DATA_WIDTH-1:0] win_q [9];
    logic [DATA_WIDTH-1:0] win_d [9];

    logic valid_q, valid_d;
    logic last_q, last_d;

    // A start-of-frame pixel overrides the counters so a partial frame is simply abandoned.
    always_comb begin
        cur_col = pixel_sof ? '0 : col_q;
        cur_row = pixel_sof ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        lb0_rd = lb0_mem[cur_col];
        lb1_rd = lb1_mem[cur_col];
    end

    always_comb begin
        for (int g = 0; g < 9; g++) begin
            win_d[g] = win_q[g];
        end
        if (pixel_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = pixel_in;
        end
    end

    // Rows 0-1 and columns 0-1 are gated, so stale line-buffer data and row-wrapped
    // columns never reach a valid window.
    always_comb begin
        valid_d = pixel_valid && (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
        last_d  = valid_d && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int g = 0; g < 9; g++) begin
                win_q[g] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            for (int g = 0; g < 9; g++) begin
                win_q[g] <= win_d[g];
            end
        end
    end

    // Line buffers are plain RAM: no reset, read-before-write at the same column.
    always_ff @(posedge clk) begin
        if (rst_n && pixel_valid) begin
            lb1_mem[cur_col] <= lb0_rd;
            lb0_mem[cur_col] <= pixel_in;
        end
    end

    always_comb begin
        window_data = '0;
        for (int g = 0; g < 9; g++) begin
            window_data[g*DATA_WIDTH +: DATA_WIDTH] = win_q[g];
        end
    end

    assign window_valid = valid_q;

`ifdef CONV_WINDOW_LAST_EN
    assign window_last = last_q;
`else
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (5x4 image) against a frame-array reference model.
// Optional feature macro: CONV_WINDOW_LAST_EN (window_last checks).
module tb_conv_window_gen;

  localparam int DW   = 8;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int WINW = 9 * DW;

  localparam logic [WINW-1:0] S1_FIRST =
    {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
  localparam logic [WINW-1:0] S1_LAST =
    {8'h34, 8'h33, 8'h32, 8'h24, 8'h23, 8'h22, 8'h14, 8'h13, 8'h12};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   pixel_in;
  logic            pixel_valid;
  logic            pixel_sof;
  logic [WINW-1:0] window_data;
  logic            window_valid;
`ifdef CONV_WINDOW_LAST_EN
  logic            window_last;
`endif

  conv_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_sof    (pixel_sof),
    .window_data  (window_data),
`ifdef CONV_WINDOW_LAST_EN
    .window_valid (window_valid),
    .window_last  (window_last)
`else
    .window_valid (window_valid)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard: observed windows vs expected windows from the model
  logic [WINW-1:0] got_q[$];
  bit              got_last_q[$];
  bit              got_acc_q[$];
  int              stray_last;
  logic [WINW-1:0] exp_q[$];
  bit              exp_last_q[$];

  // reference model: the current frame as a 2-D array addressed by (row, col)
  logic [DW-1:0] img [H][W];
  int            mr, mc;

  task automatic model_reset();
    mr = 0;
    mc = 0;
  endtask

  task automatic model_pixel(input bit sof, input logic [DW-1:0] v);
    logic [WINW-1:0] w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = v;
    if (mr >= 2 && mc >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(r*3 + c)*DW +: DW] = img[mr - 2 + r][mc - 2 + c];
      exp_q.push_back(w);
      exp_last_q.push_back(mr == H-1 && mc == W-1);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    got_last_q.delete();
    got_acc_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    stray_last = 0;
  endtask

  // driver: one clock with given inputs, then capture any window produced
  task automatic step(input bit v, input bit sof, input logic [DW-1:0] pix);
    pixel_valid = v;
    pixel_sof   = sof;
    pixel_in    = pix;
    if (v) model_pixel(sof, pix);
    @(posedge clk);
    #1;
    if (window_valid) begin
      got_q.push_back(window_data);
      got_acc_q.push_back(v);
`ifdef CONV_WINDOW_LAST_EN
      got_last_q.push_back(window_last);
`else
      got_last_q.push_back(1'b0);
`endif
    end
`ifdef CONV_WINDOW_LAST_EN
    if (window_last && !window_valid) stray_last++;
`endif
    pixel_valid = 1'b0;
    pixel_sof   = 1'b0;
  endtask

  // pixels value = base + row*16 + col, sof on first pixel, optional random gaps
  task automatic feed_pixels(input int base, input int max_gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int k = 0; k < gap; k++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b1, i == 0, 8'(base + (i / W) * 16 + (i % W)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    pixel_sof = 1'b0;
    pixel_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", window_valid);
    end
    checks++;
    if (window_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", window_data);
    end
`ifdef CONV_WINDOW_LAST_EN
    checks++;
    if (window_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_last: got %b want 0", window_last);
    end
`endif
    rst_n = 1'b1;
    model_reset();
    clear_sb();
    repeat (3) step(1'b0, 1'b0, 8'($urandom));
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL idle_no_window: got %0d windows want 0", got_q.size());
    end
  endtask

  task automatic test_single_frame();
    logic [WINW-1:0] first, last;
    int mism, sum, bad_acc;
    clear_sb();
    feed_pixels(0, 0, W*H);
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL s1_count: got %0d windows want 6", got_q.size());
    end
    first = (got_q.size() > 0) ? got_q[0] : 'x;
    last  = (got_q.size() > 0) ? got_q[got_q.size()-1] : 'x;
    checks++;
    if (first !== S1_FIRST) begin
      errors++;
      $display("FAIL s1_first: got %h want %h", first, S1_FIRST);
    end
    checks++;
    if (last !== S1_LAST) begin
      errors++;
      $display("FAIL s1_last: got %h want %h", last, S1_LAST);
    end
    sum = 0;
    for (int g = 0; g < 9; g++) sum += int'(first[g*DW +: DW]);
    checks++;
    if (sum !== 153) begin
      errors++;
      $display("FAIL s1_mac_sum: got %0d want 153", sum);
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL s1_model: %0d mismatches, got %0d want %0d windows", mism, got_q.size(), exp_q.size());
    end
    bad_acc = 0;
    foreach (got_acc_q[i]) if (!got_acc_q[i]) bad_acc++;
    checks++;
    if (bad_acc != 0) begin
      errors++;
      $display("FAIL s1_latency: %0d windows not 1 cycle after a pixel, want 0", bad_acc);
    end
`ifdef CONV_WINDOW_LAST_EN
    mism = 0;
    for (int i = 0; i < got_last_q.size() && i < exp_last_q.size(); i++)
      if (got_last_q[i] !== exp_last_q[i]) mism++;
    checks++;
    if (mism != 0 || stray_last != 0) begin
      errors++;
      $display("FAIL s1_last_flag: %0d flag mismatches, %0d stray, want 0", mism, stray_last);
    end
    checks++;
    if (got_last_q.size() != 6 || got_last_q[got_last_q.size()-1] !== 1'b1) begin
      errors++;
      $display("FAIL s1_last_on_6th: got %0d windows, final flag not set, want flag on 6th");
    end
`endif
  endtask

  task automatic test_gaps();
    int mism, bad_acc;
    clear_sb();
    feed_pixels(0, 3, W*H);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (got_q.size() != 6 || exp_q.size() != 6 || mism != 0) begin
      errors++;
      $display("FAIL gaps_windows: got %0d windows, %0d mismatches, want 6 and 0", got_q.size(), mism);
    end
    bad_acc = 0;
    foreach (got_acc_q[i]) if (!got_acc_q[i]) bad_acc++;
    checks++;
    if (bad_acc != 0) begin
      errors++;
      $display("FAIL gaps_valid_in_gap: got %0d windows in gap cycles want 0", bad_acc);
    end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== S1_FIRST) begin
      errors++;
      $display("FAIL gaps_first: got %h want %h", got_q[0], S1_FIRST);
    end
  endtask

  task automatic test_back_to_back();
    logic [WINW-1:0] w6;
    int mism;
    clear_sb();
    feed_pixels(0, 0, W*H);
    feed_pixels(8'h80, 0, W*H);
    checks++;
    if (got_q.size() != 12) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 12", got_q.size());
    end
    w6 = (got_q.size() > 6) ? got_q[6] : 'x;
    checks++;
    if (w6[0 +: DW] !== 8'h80 || w6[8*DW +: DW] !== 8'hA2) begin
      errors++;
      $display("FAIL b2b_frame2_first: got g0=%h g8=%h want g0=80 g8=a2", w6[0 +: DW], w6[8*DW +: DW]);
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_model: %0d mismatches, got %0d want %0d", mism, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_sof_resync();
    int mism;
    clear_sb();
    feed_pixels(0, 0, 3*W + 1);
    feed_pixels(0, 0, W*H);
    checks++;
    if (got_q.size() != 9) begin
      errors++;
      $display("FAIL sof_count: got %0d want 9", got_q.size());
    end
    checks++;
    if (got_q.size() < 9 || got_q[3] !== S1_FIRST || got_q[8] !== S1_LAST) begin
      errors++;
      $display("FAIL sof_frame: post-sof windows differ from a clean frame (%0d windows)", got_q.size());
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sof_model: %0d mismatches, got %0d want %0d", mism, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int mism;
    clear_sb();
    feed_pixels(0, 0, 2*W + 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b want 0", window_valid);
    end
`ifdef CONV_WINDOW_LAST_EN
    checks++;
    if (window_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_last: got %b want 0", window_last);
    end
`endif
    rst_n = 1'b1;
    model_reset();
    clear_sb();
    // fresh frame without sof: the counters alone must restart at (0,0)
    for (int i = 0; i < W*H; i++) step(1'b1, 1'b0, 8'((i / W) * 16 + (i % W)));
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (got_q.size() != 6 || mism != 0 || got_q[0] !== S1_FIRST) begin
      errors++;
      $display("FAIL midreset_frame: got %0d windows, %0d mismatches, want 6 clean", got_q.size(), mism);
    end
  endtask

  task automatic test_random();
    int mism;
    clear_sb();
    for (int i = 0; i < 4*W*H; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b1, (i == 0) || ($urandom_range(0, 24) == 0), 8'($urandom));
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_model: %0d mismatches, got %0d want %0d windows", mism, got_q.size(), exp_q.size());
    end
`ifdef CONV_WINDOW_LAST_EN
    mism = 0;
    for (int i = 0; i < got_last_q.size() && i < exp_last_q.size(); i++)
      if (got_last_q[i] !== exp_last_q[i]) mism++;
    checks++;
    if (mism != 0 || stray_last != 0) begin
      errors++;
      $display("FAIL random_last: %0d flag mismatches, %0d stray, want 0", mism, stray_last);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_sof_resync();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
